// File: rtl/led_output_stage.sv
`default_nettype none
// ============================================================================
// Module   : led_output_stage
// Brief    : Combines per-LED PWM with group dim/blink, applies sleep/invert,
//            and registers the four LED pad drives.
// Revision : 1.0
// ============================================================================
module led_output_stage #(
    parameter int BLINK_DIV = 64
) (
    input  logic       clk_pwm,
    input  logic       rst,
    input  logic       sleep,
    input  logic [3:0] pwm_individual,
    input  logic [7:0] grppwm_reg,
    input  logic [7:0] grpfreq_reg,
    input  logic       dmblnk_reg,
    input  logic [7:0] ledout_reg,
    input  logic       invert,
    output logic [3:0] led_out,
    output logic       grp_sync
);

    localparam int                 c_PRE_W   = $clog2(BLINK_DIV);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(BLINK_DIV - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE = c_PRE_W'(1);

    logic [c_PRE_W-1:0] r_pre;
    logic [7:0]         r_dim_cnt;
    logic [7:0]         r_blink_cnt;
    logic [7:0]         r_grppwm_s;
    logic [7:0]         r_grpfreq_s;
    logic               r_dmblnk_s;

    logic               w_tick;
    logic               w_dim_wrap;
    logic               w_blink_wrap;
    logic               w_boundary;
    logic               w_mode_chg;
    logic               w_grp_on;
    logic [16:0]        w_blink_thr;
    logic [3:0]         w_sel;
    logic [3:0]         w_led_nxt;

    assign w_tick       = (r_pre == c_PRE_MAX);
    assign w_dim_wrap   = (r_dim_cnt == 8'hFF);
    assign w_blink_wrap = w_tick && (r_blink_cnt == r_grpfreq_s);
    assign w_boundary   = r_dmblnk_s ? w_blink_wrap : w_dim_wrap;
    assign w_mode_chg   = w_boundary && (dmblnk_reg != r_dmblnk_s);

    // Full-width product so the blink on-fraction never truncates (max 255*256).
    assign w_blink_thr = 17'(r_grppwm_s) * (17'(r_grpfreq_s) + 17'd1);
    assign w_grp_on    = r_dmblnk_s ? ({1'b0, r_blink_cnt, 8'h00} < w_blink_thr)
                                    : (r_dim_cnt < r_grppwm_s);

    // Select: 00 off, 01 on, 10 individual PWM, 11 individual PWM gated by group.
    for (genvar gi = 0; gi < 4; gi++) begin : g_led_sel
        assign w_sel[gi] = ledout_reg[2*gi+1]
                         ? (pwm_individual[gi] & (~ledout_reg[2*gi] | w_grp_on))
                         : ledout_reg[2*gi];
    end

    assign w_led_nxt = (sleep ? 4'h0 : w_sel) ^ {4{invert}};

    always_ff @(posedge clk_pwm or posedge rst) begin
        if (rst) begin
            r_pre       <= '0;
            r_dim_cnt   <= 8'h00;
            r_blink_cnt <= 8'h00;
            r_grppwm_s  <= 8'hFF;
            r_grpfreq_s <= 8'h00;
            r_dmblnk_s  <= 1'b0;
            grp_sync    <= 1'b0;
            led_out     <= 4'h0;
        end else begin
            led_out <= w_led_nxt;
            if (sleep) begin
                r_pre       <= '0;
                r_dim_cnt   <= 8'h00;
                r_blink_cnt <= 8'h00;
                r_grppwm_s  <= grppwm_reg;
                r_grpfreq_s <= grpfreq_reg;
                r_dmblnk_s  <= dmblnk_reg;
                grp_sync    <= 1'b0;
            end else begin
                grp_sync <= w_boundary;
                if (w_boundary) begin
                    r_grppwm_s  <= grppwm_reg;
                    r_grpfreq_s <= grpfreq_reg;
                    r_dmblnk_s  <= dmblnk_reg;
                end
                if (w_mode_chg) begin
                    r_pre       <= '0;
                    r_dim_cnt   <= 8'h00;
                    r_blink_cnt <= 8'h00;
                end else begin
                    r_pre     <= w_tick ? '0 : (r_pre + c_PRE_ONE);
                    r_dim_cnt <= r_dim_cnt + 8'd1;
                    if (w_tick) begin
                        r_blink_cnt <= w_blink_wrap ? 8'h00 : (r_blink_cnt + 8'd1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_output_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_output_stage
// Brief    : Self-checking bench for led_output_stage (select table plus
//            dim, shadowing, blink, sleep and reset sequences).
// Revision : 1.0
// ============================================================================
module tb_led_output_stage;

    logic       clk_pwm = 1'b0;
    logic       rst;
    logic       sleep;
    logic [3:0] pwm_individual;
    logic [7:0] grppwm_reg;
    logic [7:0] grpfreq_reg;
    logic       dmblnk_reg;
    logic [7:0] ledout_reg;
    logic       invert;
    logic [3:0] led_out;
    logic       grp_sync;

    led_output_stage #(.BLINK_DIV(4)) dut (
        .clk_pwm        (clk_pwm),
        .rst            (rst),
        .sleep          (sleep),
        .pwm_individual (pwm_individual),
        .grppwm_reg     (grppwm_reg),
        .grpfreq_reg    (grpfreq_reg),
        .dmblnk_reg     (dmblnk_reg),
        .ledout_reg     (ledout_reg),
        .invert         (invert),
        .led_out        (led_out),
        .grp_sync       (grp_sync)
    );

    always #5 clk_pwm = ~clk_pwm;

    typedef struct packed {
        logic [7:0] ledout;
        logic [3:0] pwm;
        logic       inv;
        logic       slp;
        logic [3:0] exp_led;
    } vec_t;

    vec_t       vecs [12];
    logic [4:0] sb_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Expected {grp_sync, led_out} is queued with the stimulus and popped after the edge.
    task automatic cyc(input string nm, input logic [4:0] exp_v, input logic [4:0] mask);
        logic [4:0] e;
        logic [4:0] got;
        sb_q.push_back(exp_v);
        @(posedge clk_pwm);
        #1;
        got = {grp_sync, led_out};
        e   = sb_q.pop_front();
        n_cmp++;
        if ((got & mask) !== (e & mask)) begin
            n_bad++;
            $display("FAIL %s @%0t: got sync/led=%b required %b (mask %b)", nm, $time, got, e, mask);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp_v);
        n_cmp++;
        if (got != exp_v) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d required %0d", nm, $time, got, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         off;
        int         per;
        int         duty [4];
        logic       l;

        duty = '{64, 192, 0, 255};
        vecs[0]  = '{8'h00, 4'hF, 1'b0, 1'b0, 4'h0};
        vecs[1]  = '{8'h55, 4'h0, 1'b0, 1'b0, 4'hF};
        vecs[2]  = '{8'hAA, 4'hA, 1'b0, 1'b0, 4'hA};
        vecs[3]  = '{8'hAA, 4'h5, 1'b0, 1'b0, 4'h5};
        vecs[4]  = '{8'hAA, 4'h5, 1'b1, 1'b0, 4'hA};
        vecs[5]  = '{8'h55, 4'h0, 1'b1, 1'b0, 4'h0};
        vecs[6]  = '{8'h00, 4'h0, 1'b1, 1'b0, 4'hF};
        vecs[7]  = '{8'h55, 4'hF, 1'b0, 1'b1, 4'h0};
        vecs[8]  = '{8'h55, 4'hF, 1'b1, 1'b1, 4'hF};
        vecs[9]  = '{8'hE4, 4'h0, 1'b0, 1'b0, 4'h2};
        vecs[10] = '{8'h9C, 4'h8, 1'b0, 1'b0, 4'hC};
        vecs[11] = '{8'h55, 4'hF, 1'b0, 1'b0, 4'hF};

        rst            = 1'b1;
        sleep          = 1'b0;
        pwm_individual = 4'h0;
        grppwm_reg     = 8'hFF;
        grpfreq_reg    = 8'h00;
        dmblnk_reg     = 1'b0;
        ledout_reg     = 8'h00;
        invert         = 1'b0;
        #1;
        chk("reset_led", int'(led_out), 0);
        chk("reset_sync", int'(grp_sync), 0);
        repeat (2) @(posedge clk_pwm);
        @(negedge clk_pwm);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            ledout_reg     = vecs[i].ledout;
            pwm_individual = vecs[i].pwm;
            invert         = vecs[i].inv;
            sleep          = vecs[i].slp;
            cyc($sformatf("vec%0d", i), {1'b0, vecs[i].exp_led}, 5'h0F);
        end

        // Asynchronous reset in the middle of a cycle.
        grppwm_reg     = 8'h40;
        ledout_reg     = 8'hE4;
        pwm_individual = 4'hF;
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_led", int'(led_out), 0);
        chk("async_rst_sync", int'(grp_sync), 0);
        @(negedge clk_pwm);
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk_pwm);
            #1;
            n++;
        end while (!grp_sync && n < 600);
        chk("rst_first_sync", n, 256);

        // Four dim periods: duty 64, 192 (shadowed mid-period write), 0, 255.
        for (int j = 1; j <= 1024; j++) begin
            off = (j - 1) % 256;
            per = (j - 1) / 256;
            l   = (off < duty[per]);
            cyc($sformatf("dim_p%0d_o%0d", per, off), {((j % 256) == 0), l, 3'b110}, 5'h1F);
            if (j == 100) grppwm_reg = 8'hC0;
            if (j == 356) grppwm_reg = 8'h00;
            if (j == 612) grppwm_reg = 8'hFF;
            if (j == 868) begin
                grppwm_reg  = 8'h80;
                grpfreq_reg = 8'h03;
                dmblnk_reg  = 1'b1;
            end
            if (j == 1024) ledout_reg = 8'h03;
        end

        // Blink: 16-cycle period, half on; then grpfreq 0 gives a 4-cycle always-on period.
        for (int k = 1; k <= 48; k++) begin
            if (k <= 32) begin
                l = (((k - 1) % 16) < 8);
                cyc($sformatf("blink_%0d", k), {((k % 16) == 0), 3'b000, l}, 5'h1F);
            end else begin
                cyc($sformatf("blink_f0_%0d", k), {(((k - 32) % 4) == 0), 4'h1}, 5'h1F);
            end
            if (k == 20) grpfreq_reg = 8'h00;
        end

        // Sleep with inverted pads, reprogramming to dim mode while asleep.
        ledout_reg = 8'h55;
        invert     = 1'b1;
        sleep      = 1'b1;
        for (int m = 1; m <= 10; m++) begin
            cyc($sformatf("sleep_%0d", m), {1'b0, 4'hF}, 5'h1F);
            if (m == 3) begin
                dmblnk_reg = 1'b0;
                grppwm_reg = 8'h40;
            end
        end
        sleep      = 1'b0;
        ledout_reg = 8'hFF;
        for (int j = 1; j <= 256; j++) begin
            cyc($sformatf("wake_%0d", j), {(j == 256), ((j - 1) < 64) ? 4'h0 : 4'hF}, 5'h1F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
